// File: rtl/glyph_pkg.sv
// rtl/glyph_pkg.sv - shared glyph constants, code/mask types and mask builder
package glyph_pkg;
  localparam int GLYPH_COLS  = 4;
  localparam int GLYPH_ROWS  = 5;
  localparam int GLYPH_PITCH = 5;
  localparam int CODE_W      = 5;
  localparam int CODE_BLANK  = 0;
  localparam int CODE_A      = 1;

  typedef logic [GLYPH_COLS*GLYPH_ROWS-1:0] glyph_mask_t;
  typedef logic [CODE_W-1:0]                glyph_code_t;

  // Rows are written MSB = leftmost column; the mask stores col 0 at bit row*4.
  function automatic glyph_mask_t glyph_from_rows(input logic [3:0] r0, input logic [3:0] r1,
                                                  input logic [3:0] r2, input logic [3:0] r3,
                                                  input logic [3:0] r4);
    logic [19:0] rows;
    glyph_mask_t m;
    rows = {r4, r3, r2, r1, r0};
    m = '0;
    for (int r = 0; r < GLYPH_ROWS; r++) begin
      for (int c = 0; c < GLYPH_COLS; c++) begin
        m[r*GLYPH_COLS + c] = rows[r*GLYPH_COLS + (GLYPH_COLS-1-c)];
      end
    end
    return m;
  endfunction
endpackage

// File: rtl/glyph_string_renderer_if.sv
// rtl/glyph_string_renderer_if.sv - pixel, buffer-write and output signals of the renderer
interface glyph_string_renderer_if
  import glyph_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int IDX_W   = 4
);
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               pix_valid;
  logic [COORD_W-1:0] x0;
  logic [COORD_W-1:0] y0;
  logic               en;
  logic               frame_tick;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  glyph_code_t        wr_code;
  logic               blink;
  logic               disp;
  logic               disp_valid;

  modport master (
    output x, y, pix_valid, x0, y0, en, frame_tick, wr_en, wr_idx, wr_code, blink,
    input  disp, disp_valid
  );

  modport slave (
    input  x, y, pix_valid, x0, y0, en, frame_tick, wr_en, wr_idx, wr_code, blink,
    output disp, disp_valid
  );
endinterface

// File: rtl/glyph_rom.sv
// rtl/glyph_rom.sv - combinational 4x5 font lookup for A..Z; other codes are blank
module glyph_rom
  import glyph_pkg::*;
(
  input  glyph_code_t i_code,
  output glyph_mask_t o_mask
);
  always_comb begin
    o_mask = '0;
    case (i_code)
      5'd1:  o_mask = glyph_from_rows(4'b0110, 4'b1001, 4'b1111, 4'b1001, 4'b1001);
      5'd2:  o_mask = glyph_from_rows(4'b1110, 4'b1001, 4'b1110, 4'b1001, 4'b1110);
      5'd3:  o_mask = glyph_from_rows(4'b0111, 4'b1000, 4'b1000, 4'b1000, 4'b0111);
      5'd4:  o_mask = glyph_from_rows(4'b1110, 4'b1001, 4'b1001, 4'b1001, 4'b1110);
      5'd5:  o_mask = glyph_from_rows(4'b1111, 4'b1000, 4'b1110, 4'b1000, 4'b1111);
      5'd6:  o_mask = glyph_from_rows(4'b1111, 4'b1000, 4'b1110, 4'b1000, 4'b1000);
      5'd7:  o_mask = glyph_from_rows(4'b0111, 4'b1000, 4'b1011, 4'b1001, 4'b0111);
      5'd8:  o_mask = glyph_from_rows(4'b1001, 4'b1001, 4'b1111, 4'b1001, 4'b1001);
      5'd9:  o_mask = glyph_from_rows(4'b1110, 4'b0100, 4'b0100, 4'b0100, 4'b1110);
      5'd10: o_mask = glyph_from_rows(4'b0001, 4'b0001, 4'b0001, 4'b1001, 4'b0110);
      5'd11: o_mask = glyph_from_rows(4'b1001, 4'b1010, 4'b1100, 4'b1010, 4'b1001);
      5'd12: o_mask = glyph_from_rows(4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1111);
      5'd13: o_mask = glyph_from_rows(4'b1001, 4'b1111, 4'b1111, 4'b1001, 4'b1001);
      5'd14: o_mask = glyph_from_rows(4'b1001, 4'b1101, 4'b1011, 4'b1001, 4'b1001);
      5'd15: o_mask = glyph_from_rows(4'b0110, 4'b1001, 4'b1001, 4'b1001, 4'b0110);
      5'd16: o_mask = glyph_from_rows(4'b1110, 4'b1001, 4'b1110, 4'b1000, 4'b1000);
      5'd17: o_mask = glyph_from_rows(4'b0110, 4'b1001, 4'b1001, 4'b1011, 4'b0111);
      5'd18: o_mask = glyph_from_rows(4'b1110, 4'b1001, 4'b1110, 4'b1001, 4'b1001);
      5'd19: o_mask = glyph_from_rows(4'b0111, 4'b1000, 4'b0110, 4'b0001, 4'b1110);
      5'd20: o_mask = glyph_from_rows(4'b1111, 4'b0100, 4'b0100, 4'b0100, 4'b0100);
      5'd21: o_mask = glyph_from_rows(4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0110);
      5'd22: o_mask = glyph_from_rows(4'b1001, 4'b1001, 4'b1001, 4'b0110, 4'b0110);
      5'd23: o_mask = glyph_from_rows(4'b1001, 4'b1001, 4'b1111, 4'b1111, 4'b1001);
      5'd24: o_mask = glyph_from_rows(4'b1001, 4'b1001, 4'b0110, 4'b1001, 4'b1001);
      5'd25: o_mask = glyph_from_rows(4'b1001, 4'b1001, 4'b0110, 4'b0100, 4'b0100);
      5'd26: o_mask = glyph_from_rows(4'b1111, 4'b0001, 4'b0110, 4'b1000, 4'b1111);
      default: o_mask = '0;
    endcase
  end
endmodule

// File: rtl/glyph_string_renderer.sv
// rtl/glyph_string_renderer.sv - 2-stage pixel renderer for a double-buffered glyph string
// Optional frame blink gated by macro GLYPH_STRING_BLINK_EN.
module glyph_string_renderer
  import glyph_pkg::*;
#(
  parameter int COORD_W   = 10,
  parameter int MAX_CHARS = 8,
  parameter int CELL_LOG2 = 3,
  parameter int IDX_W     = 4
)(
  input logic                     clk,
  input logic                     rst_n,
  glyph_string_renderer_if.slave  bus
);
  localparam int CX_W = COORD_W + 1 - CELL_LOG2;
  localparam logic [COORD_W:0] W_PIX = (COORD_W+1)'((GLYPH_PITCH*MAX_CHARS - 1) << CELL_LOG2);
  localparam logic [COORD_W:0] H_PIX = (COORD_W+1)'(GLYPH_ROWS << CELL_LOG2);

  glyph_code_t      r_shadow [MAX_CHARS];
  glyph_code_t      r_active [MAX_CHARS];
  logic             r_inside, r_pv, r_disp, r_disp_valid;
  logic [IDX_W-1:0] r_char_idx;
  logic [2:0]       r_col, r_row;

  logic [COORD_W:0] w_dx, w_dy;
  logic [CX_W-1:0]  w_cx, w_base;
  logic [IDX_W-1:0] w_char_idx;
  logic [2:0]       w_col, w_row;
  logic             w_inside, w_wr_ok, w_blink_ok, w_glyph_bit;
  logic [4:0]       w_bit_idx;
  glyph_code_t      w_code;
  glyph_mask_t      w_mask;

  // One extra bit keeps x - x0 from wrapping into the visible window.
  assign w_dx     = {1'b0, bus.x} - {1'b0, bus.x0};
  assign w_dy     = {1'b0, bus.y} - {1'b0, bus.y0};
  assign w_inside = (bus.x > bus.x0) && (bus.y > bus.y0) && (w_dx < W_PIX) && (w_dy < H_PIX);
  assign w_cx     = w_dx[COORD_W:CELL_LOG2];
  assign w_row    = w_dy[CELL_LOG2 +: 3];

  always_comb begin
    w_char_idx = '0;
    w_base     = '0;
    for (int i = 1; i < MAX_CHARS; i++) begin
      if (w_cx >= CX_W'(GLYPH_PITCH*i)) begin
        w_char_idx = IDX_W'(i);
        w_base     = CX_W'(GLYPH_PITCH*i);
      end
    end
    w_col = 3'(w_cx - w_base);
  end

  assign w_wr_ok = bus.wr_en && ({1'b0, bus.wr_idx} < (IDX_W+1)'(MAX_CHARS));

  // A write landing on the commit cycle is forwarded into the active copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_CHARS; i++) begin
        r_shadow[i] <= glyph_code_t'(CODE_BLANK);
        r_active[i] <= glyph_code_t'(CODE_BLANK);
      end
    end else begin
      for (int i = 0; i < MAX_CHARS; i++) begin
        if (w_wr_ok && bus.wr_idx == IDX_W'(i))
          r_shadow[i] <= bus.wr_code;
        if (bus.frame_tick)
          r_active[i] <= (w_wr_ok && bus.wr_idx == IDX_W'(i)) ? bus.wr_code : r_shadow[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inside   <= 1'b0;
      r_pv       <= 1'b0;
      r_char_idx <= '0;
      r_col      <= '0;
      r_row      <= '0;
    end else begin
      r_inside   <= w_inside && bus.en && bus.pix_valid;
      r_pv       <= bus.pix_valid;
      r_char_idx <= w_char_idx;
      r_col      <= w_col;
      r_row      <= w_row;
    end
  end

  always_comb begin
    w_code = glyph_code_t'(CODE_BLANK);
    for (int i = 0; i < MAX_CHARS; i++) begin
      if (r_char_idx == IDX_W'(i))
        w_code = r_active[i];
    end
  end

  glyph_rom u_rom (
    .i_code (w_code),
    .o_mask (w_mask)
  );

  assign w_bit_idx   = {r_row, 2'b00} + {3'b000, r_col[1:0]};
  assign w_glyph_bit = w_mask[w_bit_idx];

`ifdef GLYPH_STRING_BLINK_EN
  logic [4:0] r_blink_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_blink_cnt <= '0;
    else if (bus.frame_tick)
      r_blink_cnt <= r_blink_cnt + 5'd1;
  end
  assign w_blink_ok = !(bus.blink && r_blink_cnt[4]);
`else
  assign w_blink_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_disp       <= 1'b0;
      r_disp_valid <= 1'b0;
    end else begin
      r_disp       <= r_inside && (r_col != 3'd4) && w_glyph_bit && w_blink_ok;
      r_disp_valid <= r_pv;
    end
  end

  assign bus.disp       = r_disp;
  assign bus.disp_valid = r_disp_valid;
endmodule

// File: tb/tb_glyph_string_renderer.sv
// tb/tb_glyph_string_renderer.sv - table, directed and random checks against a string-level model
module tb_glyph_string_renderer;
  localparam int COORD_W   = 10;
  localparam int MAX_CHARS = 8;
  localparam int CELL_LOG2 = 3;
  localparam int IDX_W     = 4;
  localparam int CELL      = 1 << CELL_LOG2;
  localparam int STR_W     = (5*MAX_CHARS - 1) * CELL;
  localparam int STR_H     = 5 * CELL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  glyph_string_renderer_if #(.COORD_W(COORD_W), .IDX_W(IDX_W)) bus();

  glyph_string_renderer #(
    .COORD_W(COORD_W), .MAX_CHARS(MAX_CHARS), .CELL_LOG2(CELL_LOG2), .IDX_W(IDX_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int m_shadow [MAX_CHARS];
  int m_active [MAX_CHARS];
  int ticks;
  string font [27][5];

  typedef struct {
    int    x;
    int    y;
    bit    exp;
    string name;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < MAX_CHARS; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
    ticks = 0;
  endtask

  task automatic write(input int idx, input int code, input bit tick);
    bus.wr_en = 1'b1;
    bus.wr_idx = IDX_W'(idx);
    bus.wr_code = 5'(code);
    bus.frame_tick = tick;
    if (idx < MAX_CHARS) m_shadow[idx] = code;
    if (tick) begin
      m_active = m_shadow;
      ticks++;
    end
    step();
    bus.wr_en = 1'b0;
    bus.frame_tick = 1'b0;
  endtask

  task automatic tick_frame();
    bus.frame_tick = 1'b1;
    m_active = m_shadow;
    ticks++;
    step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic pix(input int px, input int py, input int exp, input string name);
    bus.x = COORD_W'(px);
    bus.y = COORD_W'(py);
    bus.pix_valid = 1'b1;
    step();
    bus.pix_valid = 1'b0;
    step();
    check(name, int'(bus.disp), exp);
  endtask

  function automatic bit model_lit(input int px, input int py, input int ox, input int oy,
                                   input bit en_i, input bit bl);
    int dx, dy, cx, slot, col, row, code;
    string g;
    dx = px - ox;
    dy = py - oy;
    if (!(en_i && px > ox && py > oy && dx < STR_W && dy < STR_H)) return 1'b0;
    cx = dx / CELL;
    slot = cx / 5;
    col = cx % 5;
    row = dy / CELL;
    if (col == 4) return 1'b0;
    code = m_active[slot];
    if (code < 1 || code > 26) return 1'b0;
    g = font[code][row];
    if (g[col] != 8'h23) return 1'b0;
`ifdef GLYPH_STRING_BLINK_EN
    if (bl && (ticks % 32) >= 16) return 1'b0;
`else
    if (bl && 1'b0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic stream(input int n);
    bit prev_pv, prev_d, pv, e;
    int off;
    prev_pv = 1'b0;
    prev_d = 1'b0;
    bus.pix_valid = 1'b0;
    step();
    step();
    for (int k = 0; k < n; k++) begin
      pv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) bus.x0 = COORD_W'($urandom_range(90, 600));
      off = int'($urandom_range(0, 325)) - 5;
      bus.x = COORD_W'(int'(bus.x0) + off);
      off = int'($urandom_range(0, 48)) - 3;
      bus.y = COORD_W'(int'(bus.y0) + off);
      bus.en = ($urandom_range(0, 7) != 0);
      bus.blink = 1'($urandom_range(0, 1));
      bus.pix_valid = pv;
      e = pv && model_lit(int'(bus.x), int'(bus.y), int'(bus.x0), int'(bus.y0), bus.en, bus.blink);
      step();
      check("stream_valid", int'(bus.disp_valid), int'(prev_pv));
      check("stream_disp", int'(bus.disp), int'(prev_d));
      prev_pv = pv;
      prev_d = e;
    end
    bus.pix_valid = 1'b0;
    step();
    check("stream_valid_tail", int'(bus.disp_valid), int'(prev_pv));
    check("stream_disp_tail", int'(bus.disp), int'(prev_d));
  endtask

  initial begin
    int exp_b;
    font[0]  = '{"....", "....", "....", "....", "...."};
    font[1]  = '{".##.", "#..#", "####", "#..#", "#..#"};
    font[2]  = '{"###.", "#..#", "###.", "#..#", "###."};
    font[3]  = '{".###", "#...", "#...", "#...", ".###"};
    font[4]  = '{"###.", "#..#", "#..#", "#..#", "###."};
    font[5]  = '{"####", "#...", "###.", "#...", "####"};
    font[6]  = '{"####", "#...", "###.", "#...", "#..."};
    font[7]  = '{".###", "#...", "#.##", "#..#", ".###"};
    font[8]  = '{"#..#", "#..#", "####", "#..#", "#..#"};
    font[9]  = '{"###.", ".#..", ".#..", ".#..", "###."};
    font[10] = '{"...#", "...#", "...#", "#..#", ".##."};
    font[11] = '{"#..#", "#.#.", "##..", "#.#.", "#..#"};
    font[12] = '{"#...", "#...", "#...", "#...", "####"};
    font[13] = '{"#..#", "####", "####", "#..#", "#..#"};
    font[14] = '{"#..#", "##.#", "#.##", "#..#", "#..#"};
    font[15] = '{".##.", "#..#", "#..#", "#..#", ".##."};
    font[16] = '{"###.", "#..#", "###.", "#...", "#..."};
    font[17] = '{".##.", "#..#", "#..#", "#.##", ".###"};
    font[18] = '{"###.", "#..#", "###.", "#..#", "#..#"};
    font[19] = '{".###", "#...", ".##.", "...#", "###."};
    font[20] = '{"####", ".#..", ".#..", ".#..", ".#.."};
    font[21] = '{"#..#", "#..#", "#..#", "#..#", ".##."};
    font[22] = '{"#..#", "#..#", "#..#", ".##.", ".##."};
    font[23] = '{"#..#", "#..#", "####", "####", "#..#"};
    font[24] = '{"#..#", "#..#", ".##.", "#..#", "#..#"};
    font[25] = '{"#..#", "#..#", ".##.", ".#..", ".#.."};
    font[26] = '{"####", "...#", ".##.", "#...", "####"};

    vecs[0] = '{101, 101, 1'b1, "r_row0_col0"};
    vecs[1] = '{125, 101, 1'b0, "r_row0_col3"};
    vecs[2] = '{101, 109, 1'b1, "r_row1_col0"};
    vecs[3] = '{125, 109, 1'b1, "r_row1_col3"};
    vecs[4] = '{133, 101, 1'b0, "gap_cell"};
    vecs[5] = '{100, 101, 1'b0, "x0_edge"};
    vecs[6] = '{101, 140, 1'b0, "dy_eq_h"};
    vecs[7] = '{101, 100, 1'b0, "y0_edge"};
    vecs[8] = '{412, 101, 1'b0, "dx_eq_w"};

    bus.x = '0; bus.y = '0; bus.pix_valid = 1'b0; bus.x0 = '0; bus.y0 = '0;
    bus.en = 1'b0; bus.frame_tick = 1'b0; bus.wr_en = 1'b0; bus.wr_idx = '0;
    bus.wr_code = '0; bus.blink = 1'b0;
    model_clear();

    rst_n = 1'b0;
    step(); step(); step();
    check("reset_disp", int'(bus.disp), 0);
    check("reset_disp_valid", int'(bus.disp_valid), 0);
    rst_n = 1'b1;

    bus.x0 = 10'd100; bus.y0 = 10'd100; bus.en = 1'b1;
    write(0, 18, 1'b1);
    for (int i = 0; i < 9; i++) pix(vecs[i].x, vecs[i].y, int'(vecs[i].exp), vecs[i].name);

    write(1, 1, 1'b0);
    pix(150, 101, 0, "slot1_before_commit");
    tick_frame();
    pix(150, 101, 1, "slot1_a_row0_col1");
    pix(141, 101, 0, "slot1_a_row0_col0");
    pix(157, 101, 1, "slot1_a_row0_col2");

    pix(181, 101, 0, "slot2_blank");
    write(2, 8, 1'b1);
    pix(181, 101, 1, "fwd_write_tick");

    write(9, 0, 1'b1);
    pix(150, 101, 1, "idx9_slot1_kept");
    pix(101, 101, 1, "idx9_slot0_kept");

    bus.x0 = 10'd1000;
    pix(5, 101, 0, "x0_1000_wrap");
    pix(1001, 101, 1, "x0_1000_hit");
    bus.x0 = 10'd100;

    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 6; w++)
        write(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), $urandom_range(0, 3) == 0);
      tick_frame();
      stream(64);
    end

    bus.x0 = 10'd100; bus.y0 = 10'd100; bus.en = 1'b1; bus.blink = 1'b0;
    write(0, 18, 1'b1);
    bus.x = 10'd101; bus.y = 10'd101; bus.pix_valid = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    check("midreset_disp", int'(bus.disp), 0);
    check("midreset_disp_valid", int'(bus.disp_valid), 0);
    rst_n = 1'b1;
    model_clear();
    step();
    check("post_reset_valid_c1", int'(bus.disp_valid), 0);
    step();
    check("post_reset_valid_c2", int'(bus.disp_valid), 1);
    check("post_reset_blank", int'(bus.disp), 0);
    bus.pix_valid = 1'b0;
    step();

    write(0, 18, 1'b1);
    bus.blink = 1'b1;
    for (int f = 0; f < 32; f++) begin
      exp_b = int'(model_lit(101, 101, 100, 100, 1'b1, 1'b1));
      pix(101, 101, exp_b, "blink_frame");
      tick_frame();
    end
    for (int f = 0; f < 16; f++) tick_frame();
    bus.blink = 1'b0;
    pix(101, 101, 1, "blink_off_lit");
    stream(32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end
endmodule

// File: doc/glyph_string_renderer.md
Name: glyph_string_renderer

Overview:
- Renders a string of up to MAX_CHARS uppercase glyphs (A–Z plus blank) at a movable on-screen origin (x0, y0).
- Each glyph is a 4-column x 5-row grid of square cells, each cell 2^CELL_LOG2 pixels on a side. Characters are placed on a 5-cell pitch: 4 glyph cells plus 1 blank gap cell.
- Sits between the VGA timing generator and the colour mux, in the score/title overlay path.
- Pixel output is pipelined. The string is double-buffered so updates appear only at frame boundaries.

Parameters:
- COORD_W, 10: width of the pixel coordinate inputs.
- MAX_CHARS, 8: number of character slots. Legal range 1..16.
- CELL_LOG2, 3: log2 of the cell size in pixels (3 gives 8x8 cells and 32x40 glyphs).
- IDX_W, 4: width of wr_idx; must satisfy 2^IDX_W >= MAX_CHARS.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous reset, active low
- x  in  COORD_W  current pixel column
- y  in  COORD_W  current pixel row
- pix_valid  in  1  x/y are valid this cycle
- x0  in  COORD_W  string origin, column
- y0  in  COORD_W  string origin, row
- en  in  1  render enable, sampled with x/y
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- wr_en  in  1  write a character code into the shadow buffer
- wr_idx  in  IDX_W  slot index to write
- wr_code  in  5  character code: 0 = blank, 1..26 = A..Z, 27..31 = blank
- blink  in  1  blink request (used only when the optional feature is compiled in)
- disp  out  1  pixel is lit
- disp_valid  out  1  disp corresponds to a pixel_valid input two cycles earlier

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-low; port names are clk and rst_n.
  - While rst_n=0 at a clk edge: disp=0, disp_valid=0, all shadow and active slots cleared to 0 (blank), pipeline registers cleared, blink counter cleared.
  - Reset asserted mid-frame drops any in-flight pixels; the next valid output appears 2 cycles after the first pix_valid following release.
- Buffers:
  - wr_en=1 writes wr_code into shadow[wr_idx]. Writes with wr_idx >= MAX_CHARS are ignored.
  - The active buffer never changes except on frame_tick, when active <= shadow (whole-string atomic commit).
  - If wr_en and frame_tick occur in the same cycle, the write is forwarded: the committed active buffer includes the new code.
  - Back-to-back writes to the same slot: the last one wins.
- Stage 1 (registered): compute dx = x - x0 and dy = y - y0 in COORD_W+1 bits so no wrap-around occurs.
  - W = (5*MAX_CHARS - 1) << CELL_LOG2; H = 5 << CELL_LOG2.
  - inside = (x > x0) && (y > y0) && (dx < W) && (dy < H). These are strict comparisons on x0/y0, and the right and bottom edges are exclusive.
  - cx = dx >> CELL_LOG2 and row = dy >> CELL_LOG2 (0..4).
  - char_idx and col are derived from cx by comparison against multiples of 5 (no divider); col = cx - 5*char_idx, range 0..4.
  - Register inside & en & pix_valid, char_idx, col, row, and pix_valid.
- Stage 2 (registered): disp = inside_q && (col_q != 4) && glyph_bit(active[char_idx_q], row_q, col_q).
  - disp_valid = pix_valid delayed by 2 cycles.
- Latency and throughput:
  - Total latency is exactly 2 clocks from x/y/pix_valid to disp.
  - Throughput is 1 pixel per clock with no stalls.
  - When disp_valid=0, disp=0.
- Glyph encoding:
  - Each glyph is a 20-bit mask with bit = row*4 + col.
  - Code 18 ('R') rows 0..4 = 1110, 1001, 1110, 1001, 1001, with the leftmost character being col 0.
- x0 or y0 changed mid-frame: takes effect on the next valid pixel; no commit is required.

Optional Feature:
- Macro GLYPH_STRING_BLINK_EN.
- Defined: an internal 5-bit counter increments on each frame_tick and wraps at 31→0. When blink=1, the stage-2 disp is additionally ANDed with ~counter[4], giving a 16 frames on / 16 frames off pattern. The counter resets to 0.
- Not defined: no counter is built and the blink port is ignored. Rendering is identical to the blink=0 case.

Decomposition:
- Shared package glyph_pkg holds:
  - constants GLYPH_COLS=4, GLYPH_ROWS=5, GLYPH_PITCH=5, CODE_W=5, CODE_BLANK=0, CODE_A=1;
  - a typedef for the 20-bit glyph mask;
  - a typedef for the 5-bit character code.
- One sub-module, glyph_rom: a purely combinational map from code to 20-bit mask (A..Z; all other codes map to 0). It is instantiated once, at stage 2.

Test Plan:
- Reset, then x0=100, y0=100, en=1, write slot0 = 18, frame_tick; pixel (101,101) → disp=1 two clocks later. Pixel (125,101) → 0. Pixel (101,109) → 1. Pixel (125,109) → 1.
- Same string; pixel (133,101), in the gap cell → 0. Pixel (100,101), on the x0 boundary → 0. Pixel (101,140), dy=40, outside H → 0.
- Write slot1 = 1 ('A') without frame_tick → the slot1 region stays blank; after frame_tick, row0 of slot1 matches the A mask. Also wr_en and frame_tick in the same cycle → the new code is visible on the next pixel.
- wr_idx=9 with MAX_CHARS=8 → no change to any slot. x0=1000 with MAX_CHARS=8 → no false hits from overflow.
- Stream 64 consecutive pixels with random pix_valid → disp_valid equals pix_valid delayed by exactly 2 clocks. Assert rst_n=0 mid-stream → disp=0 and disp_valid=0 on the following cycle.
- GLYPH_STRING_BLINK_EN defined, blink=1: disp is on for frames 0..15 and off for frames 16..31 at a lit pixel. With blink=0 the pixel is lit in all frames.
